// File: rtl/mux_n_pkg.sv
// Shared defaults and select-range helper for the registered N-way selector.
package mux_n_pkg;

  localparam int MUX_N_DEF_WIDTH = 32;
  localparam int MUX_N_DEF_N     = 4;

  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way selector; an out-of-range select yields zero.
module mux_n_comb
  import mux_n_pkg::*;
#(
  parameter int WIDTH = MUX_N_DEF_WIDTH,
  parameter int N     = MUX_N_DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   y
);

  logic [WIDTH-1:0] in_arr [N];
  logic [WIDTH-1:0] pick;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign in_arr[gi] = data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Compare-and-pick loop avoids indexing the array with an illegal select.
  always_comb begin
    pick = '0;
    for (int k = 0; k < N; k++) begin
      if (32'(sel) == k) pick = in_arr[k];
    end
  end

  assign y = sel_in_range(32'(sel), N) ? pick : '0;

endmodule

// File: rtl/mux_n_reg.sv
// N-way selector with one registered output stage and valid/ready on both sides.
// Optional MUX_N_REG_SEL_ERR_EN builds a registered out-of-range select flag.
module mux_n_reg
  import mux_n_pkg::*;
#(
  parameter int WIDTH = MUX_N_DEF_WIDTH,
  parameter int N     = MUX_N_DEF_N,
  localparam int SELW = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] data_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               sel_err
);

  logic [WIDTH-1:0] sel_data;
  logic             accept;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;

  mux_n_comb #(.WIDTH(WIDTH), .N(N)) u_comb (
    .data_in (data_in),
    .sel     (sel),
    .y       (sel_data)
  );

  // No path from in_valid: readiness depends only on held state, flush and out_ready.
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      out_d       = sel_data;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

`ifdef MUX_N_REG_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q;
    if (flush) begin
      sel_err_d = 1'b0;
    end else if (accept) begin
      sel_err_d = !sel_in_range(32'(sel), N);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;
`else
  assign sel_err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out       = out_q;

endmodule

// File: tb/tb_mux_n_reg.sv
// Directed table-driven bench: a 4-way instance for handshake behaviour and a
// 3-way instance for the out-of-range select path.
module tb_mux_n_reg;

`ifdef MUX_N_REG_SEL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush;
  logic        in_valid, in_ready, out_valid, out_ready, sel_err;
  logic [1:0]  sel;
  logic [127:0] data_in;
  logic [31:0] out;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, sel_err3;
  logic [1:0]  sel3;
  logic [95:0] data_in3;
  logic [31:0] out3;

  int checks = 0;
  int errors = 0;

  mux_n_reg #(.WIDTH(32), .N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .data_in   (data_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .sel_err   (sel_err)
  );

  mux_n_reg #(.WIDTH(32), .N(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .sel       (sel3),
    .data_in   (data_in3),
    .flush     (flush),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out       (out3),
    .sel_err   (sel_err3)
  );

  typedef struct {
    logic        rst_n;
    logic        iv;
    logic [1:0]  sel;
    logic        fl;
    logic        ordy;
    logic        chk_rdy;
    logic        rdy;
    logic        ov;
    logic [31:0] dout;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step3(input logic iv, input logic [1:0] s, input logic ordy, input logic fl,
                       input logic rdy, input logic ov, input logic [31:0] dout,
                       input logic err);
    in_valid3  = iv;
    sel3       = s;
    out_ready3 = ordy;
    flush      = fl;
    @(negedge clk);
    check("n3_in_ready", 32'(in_ready3), 32'(rdy));
    @(posedge clk);
    #1;
    check("n3_out_valid", 32'(out_valid3), 32'(ov));
    check("n3_out", out3, dout);
    check("n3_sel_err", 32'(sel_err3), 32'(err));
    $display("n3 sel=%0d flush=%0b -> out_valid=%0b out=%h sel_err=%0b",
             s, fl, out_valid3, out3, sel_err3);
  endtask

  initial begin
    data_in  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    data_in3 = {32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    in_valid3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;

    // rst_n iv sel fl ordy chk_rdy rdy ov out
    vq.push_back('{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0});
    vq.push_back('{1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hAAAA0000});
    vq.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB0001});
    vq.push_back('{1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hCCCC0002});
    vq.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDDDD0003});
    vq.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDDDD0003});
    vq.push_back('{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hCCCC0002});
    for (int i = 0; i < 4; i++)
      vq.push_back('{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hCCCC0002});
    vq.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB0001});
    vq.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hBBBB0001});
    vq.push_back('{1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hBBBB0001});
    vq.push_back('{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAAAA0000});
    vq.push_back('{1'b1, 1'b1, 2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hAAAA0000});
    vq.push_back('{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hDDDD0003});
    vq.push_back('{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hDDDD0003});
    vq.push_back('{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
    vq.push_back('{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hBBBB0001});

    foreach (vq[i]) begin
      rst_n     = vq[i].rst_n;
      in_valid  = vq[i].iv;
      sel       = vq[i].sel;
      flush     = vq[i].fl;
      out_ready = vq[i].ordy;
      @(negedge clk);
      if (vq[i].chk_rdy) check($sformatf("in_ready[%0d]", i), 32'(in_ready), 32'(vq[i].rdy));
      @(posedge clk);
      #1;
      check($sformatf("out_valid[%0d]", i), 32'(out_valid), 32'(vq[i].ov));
      check($sformatf("out[%0d]", i), out, vq[i].dout);
      check($sformatf("sel_err[%0d]", i), 32'(sel_err), 32'h0);
      $display("vec %0d rst_n=%0b iv=%0b sel=%0d flush=%0b ordy=%0b -> out_valid=%0b out=%h",
               i, vq[i].rst_n, vq[i].iv, vq[i].sel, vq[i].fl, vq[i].ordy, out_valid, out);
    end

    in_valid = 1'b0;
    // Out-of-range select on a 3-way instance, then stall, recover and flush.
    step3(1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'hCCCC0002, 1'b0);
    step3(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, EXP_ERR);
    step3(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, EXP_ERR);
    step3(1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hAAAA0000, 1'b0);
    step3(1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, EXP_ERR);
    step3(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_n_reg.md
# mux_n_reg

Parametrised N-way, WIDTH-bit selector with one registered output stage and a valid/ready handshake on both sides. It supersedes the combinational 2:1 selector in the datapath wherever a selection result feeds a pipeline boundary. Typical uses are forwarding-operand select ahead of the EX stage and writeback-source select ahead of the register file.

## Interface
Parameters:
- WIDTH, 32, data width of each input and of the output.
- N, 4, number of inputs; N >= 2, need not be a power of two.
- SELW, $clog2(N), select width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset. Synchronous, active-low: sampled only on the clk rising edge.
- in_valid  in  1  upstream has a valid select/data set.
- in_ready  out  1  block accepts this cycle.
- sel  in  SELW  binary select. Value k picks input k.
- data_in  in  N*WIDTH  flattened inputs. Input k occupies bits [k*WIDTH +: WIDTH].
- flush  in  1  synchronous discard of the held result.
- out_valid  out  1  out holds a valid result.
- out_ready  in  1  downstream accepts this cycle.
- out  out  WIDTH  registered selected data.
- sel_err  out  1  registered flag: the held result came from an out-of-range sel (see Configuration).

## Operation
- Accept condition: in_valid && in_ready. On accept:
  - out <= input[sel], or 0 if sel >= N.
  - out_valid <= 1.
  - sel_err is updated per Configuration.
- in_ready = !flush && (!out_valid || out_ready). This is combinational from registered state plus flush and out_ready. There is no combinational path from in_valid.
- Hand-off: occurs when out_valid && out_ready. If no accept happens in the same cycle, out_valid <= 0. out and sel_err keep their values.
- Accept and hand-off in the same cycle: the new value replaces the old one and out_valid stays 1. Throughput is one result per cycle.
- Stall: while out_valid && !out_ready, out, sel_err and out_valid hold their values.
- Flush: next cycle, out_valid <= 0 and sel_err <= 0. There is no accept in a flush cycle, because in_ready is forced low. out keeps its value (don't-care).
- Reset: rst_n low at a rising edge sets out_valid = 0, out = 0 and sel_err = 0. Reset takes priority over flush, accept and hand-off. While rst_n is low, in_ready follows the formula and reads 1 once out_valid has cleared, but nothing is captured.

## Timing
- Latency: 1 cycle. Data accepted at edge t appears on out with out_valid = 1 after edge t.
- Only in_ready is combinational. All other outputs are registered.
- N = 2 degenerates to a registered 2:1 selector with SELW = 1.
- Reset mid-stall: the held result is lost, and out_valid is 0 after the reset edge.
- Simultaneous flush + out_ready + out_valid: the downstream transfer completes this cycle, and out_valid is 0 next cycle.

## Configuration
- Macro: MUX_N_REG_SEL_ERR_EN.
- Defined:
  - An accept with sel >= N captures out = 0 and sel_err = 1.
  - An accept with a legal sel captures sel_err = 0.
  - sel_err is meaningful only while out_valid = 1.
- Undefined:
  - sel_err is tied 0 and no error register is built.
  - An out-of-range sel still yields out = 0.
- When N is a power of two, every sel value is legal and sel_err stays 0 in both builds.

## Structure
- The package mux_n_pkg holds:
  - MUX_N_DEF_WIDTH = 32 and MUX_N_DEF_N = 4.
  - The function sel_in_range(sel, n).
- Sub-module mux_n_comb is purely combinational. It has parameters WIDTH and N, ports data_in, sel and y, with y = 0 when the select is out of range. mux_n_reg instantiates it once and wraps it with the handshake and register stage.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 1 for 3 cycles, then release. Required: out_valid = 0, out = 0 and sel_err = 0 throughout.
- Streaming: WIDTH = 32, N = 4, data_in = {0xDDDD0003, 0xCCCC0002, 0xBBBB0001, 0xAAAA0000}, out_ready = 1, sel driven 0,1,2,3 on consecutive cycles. Required: out = 0xAAAA0000, 0xBBBB0001, 0xCCCC0002, 0xDDDD0003 one cycle later each, with no bubbles.
- Backpressure: load sel = 2, then hold out_ready = 0 for 4 cycles. Required: in_ready = 0 and out = 0xCCCC0002 held. Then out_ready = 1 with in_valid = 1 and sel = 1. Required: out = 0xBBBB0001 next cycle.
- Flush: while out_valid = 1 and out_ready = 0, pulse flush for 1 cycle with in_valid = 1. Required: in_ready = 0 in that cycle, and out_valid = 0 next cycle.
- Error path: N = 3, MUX_N_REG_SEL_ERR_EN defined, sel = 3. Required: out = 0 and sel_err = 1. Repeat with the macro undefined. Required: out = 0 and sel_err = 0.
- Reset mid-stall: hold a result with out_ready = 0, then drive rst_n = 0 for 1 cycle. Required: out_valid = 0 and out = 0 after the edge.
